// File: rtl/stk_pipe_adm_if.sv
// Command admission bundle: per-engine opcode/payload in, one-hot ack out.
// The engine side is the master, the admission stage the slave.
interface stk_pipe_adm_if #(
    parameter int ENGS_N = 4,
    parameter int DAT_W  = 128,
    parameter int OPC_W  = 2
);
    logic [ENGS_N-1:0][OPC_W-1:0] i_cmd_opcode;
    logic [ENGS_N-1:0][DAT_W-1:0] i_cmd_dat;
    logic [ENGS_N-1:0]            o_cmd_ack;

    modport master (
        output i_cmd_opcode,
        output i_cmd_dat,
        input  o_cmd_ack
    );

    modport slave (
        input  i_cmd_opcode,
        input  i_cmd_dat,
        output o_cmd_ack
    );
endinterface

// File: rtl/stk_pipe_adm.sv
// stk_pipe_adm: admits engine commands into PUSH/POP/INV FIFOs, dispatches to LK.
// Optional dispatch counters are built when STK_PIPE_ADM_PERF_EN is defined.
package stk_pkg;
    localparam int OPCODE_W = 2;
    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_INV  = 2'd3
    } opcode_t;
endpackage

module stk_pipe_adm
    import stk_pkg::*;
#(
    parameter  int ENGS_N  = 4,
    parameter  int DAT_W   = 128,
    parameter  int Q_N     = 2,
    localparam int ENGID_W = $clog2(ENGS_N)
) (
    input  logic                clk,
    input  logic                rst,
    stk_pipe_adm_if.slave       cmd_if,
    output logic                o_lk_vld_r,
    output logic [ENGID_W-1:0]  o_lk_engid_r,
    output logic [OPCODE_W-1:0] o_lk_opcode_r,
    output logic                o_lk_dat_vld_r,
    output logic [DAT_W-1:0]    o_lk_dat_r,
    input  logic                i_al_empty_r,
    input  logic                i_al_busy_r,
    output logic                o_al_alloc_r,
    input  logic                i_wrbk_vld_r,
    input  logic [ENGID_W-1:0]  i_wrbk_engid_r,
    output logic [2:0][31:0]    o_perf_cnt
);
    localparam int PTR_W = (Q_N > 1) ? $clog2(Q_N) : 1;
    localparam int CNT_W = $clog2(Q_N + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(Q_N - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(Q_N);

    // Class index: PUSH=0, POP=1, INV=2.
    function automatic logic [1:0] cls_of(input logic [OPCODE_W-1:0] op);
        return op - 2'd1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [ENGS_N-1:0]  busy_q, busy_d;
    logic [ENGID_W-1:0] enq_rr_q, enq_rr_d;
    logic [1:0]         deq_rr_q, deq_rr_d;
    logic [PTR_W-1:0]   wr_ptr_q [3];
    logic [PTR_W-1:0]   wr_ptr_d [3];
    logic [PTR_W-1:0]   rd_ptr_q [3];
    logic [PTR_W-1:0]   rd_ptr_d [3];
    logic [CNT_W-1:0]   cnt_q [3];
    logic [CNT_W-1:0]   cnt_d [3];
    logic [ENGID_W-1:0] eng_mem_q [3][Q_N];
    logic [ENGID_W-1:0] eng_mem_d [3][Q_N];
    logic [DAT_W-1:0]   dat_mem_q [Q_N];
    logic [DAT_W-1:0]   dat_mem_d [Q_N];

    logic                lk_vld_q, lk_vld_d;
    logic [ENGID_W-1:0]  lk_engid_q, lk_engid_d;
    logic [OPCODE_W-1:0] lk_opcode_q, lk_opcode_d;
    logic                lk_dat_vld_q, lk_dat_vld_d;
    logic [DAT_W-1:0]    lk_dat_q, lk_dat_d;

    logic [ENGS_N-1:0]  req;
    logic [3:0]         full;
    logic [ENGID_W-1:0] idx;
    logic               acc;
    logic [ENGID_W-1:0] gnt;
    logic [1:0]         acc_cls;
    logic [2:0]         cand;
    logic [1:0]         cidx;
    logic               hit;
    logic               dsp;
    logic [1:0]         sel;
    logic [2:0]         push;
    logic [2:0]         pop;

    // Admission: round-robin among idle engines whose class FIFO has room.
    always_comb begin
        full = '0;
        for (int c = 0; c < 3; c++) begin
            full[c] = (cnt_q[c] == CNT_FULL);
        end
        req = '0;
        for (int ch = 0; ch < ENGS_N; ch++) begin
            req[ch] = (cmd_if.i_cmd_opcode[ch] != OP_NOP) && !busy_q[ch]
                    && !full[cls_of(cmd_if.i_cmd_opcode[ch])];
        end
        acc = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = 0; k < ENGS_N; k++) begin
            idx = ENGID_W'((int'(enq_rr_q) + k) % ENGS_N);
            if (!acc && req[idx]) begin
                acc = 1'b1;
                gnt = idx;
            end
        end
        acc_cls = cls_of(cmd_if.i_cmd_opcode[gnt]);
        cmd_if.o_cmd_ack = acc ? (ENGS_N'(1) << gnt) : '0;
        enq_rr_d = enq_rr_q;
        if (acc) begin
            enq_rr_d = (int'(gnt) == ENGS_N - 1) ? '0 : gnt + ENGID_W'(1);
        end
    end

    // Dispatch: round-robin among class heads that can go this cycle.
    always_comb begin
        cand[0] = (cnt_q[0] != '0) && !i_al_empty_r;
        cand[1] = (cnt_q[1] != '0);
        cand[2] = (cnt_q[2] != '0);
        dsp = !i_al_busy_r && (cand != '0);
        hit = 1'b0;
        sel = '0;
        cidx = '0;
        for (int k = 0; k < 3; k++) begin
            cidx = 2'((int'(deq_rr_q) + k) % 3);
            if (!hit && cand[cidx]) begin
                hit = 1'b1;
                sel = cidx;
            end
        end
        deq_rr_d = deq_rr_q;
        if (dsp) begin
            deq_rr_d = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            push[c] = acc && (acc_cls == 2'(c));
            pop[c]  = dsp && (sel == 2'(c));
        end
    end

    always_comb begin
        busy_d    = busy_q;
        eng_mem_d = eng_mem_q;
        dat_mem_d = dat_mem_q;
        for (int c = 0; c < 3; c++) begin
            wr_ptr_d[c] = push[c] ? ptr_inc(wr_ptr_q[c]) : wr_ptr_q[c];
            rd_ptr_d[c] = pop[c] ? ptr_inc(rd_ptr_q[c]) : rd_ptr_q[c];
            cnt_d[c]    = cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
            if (push[c]) begin
                eng_mem_d[c][wr_ptr_q[c]] = gnt;
            end
        end
        if (push[0]) begin
            dat_mem_d[wr_ptr_q[0]] = cmd_if.i_cmd_dat[gnt];
        end
        if (acc) begin
            busy_d[gnt] = 1'b1;
        end
        // Writeback clear wins over a same-cycle set.
        if (i_wrbk_vld_r) begin
            busy_d[i_wrbk_engid_r] = 1'b0;
        end
    end

    always_comb begin
        lk_vld_d     = dsp;
        lk_engid_d   = dsp ? eng_mem_q[sel][rd_ptr_q[sel]] : '0;
        lk_opcode_d  = dsp ? OPCODE_W'(sel + 2'd1) : OP_NOP;
        lk_dat_vld_d = dsp && (sel == 2'd0);
        lk_dat_d     = lk_dat_vld_d ? dat_mem_q[rd_ptr_q[0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            enq_rr_q     <= '0;
            deq_rr_q     <= '0;
            for (int c = 0; c < 3; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            lk_vld_q     <= 1'b0;
            lk_engid_q   <= '0;
            lk_opcode_q  <= '0;
            lk_dat_vld_q <= 1'b0;
            lk_dat_q     <= '0;
        end else begin
            busy_q       <= busy_d;
            enq_rr_q     <= enq_rr_d;
            deq_rr_q     <= deq_rr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            lk_vld_q     <= lk_vld_d;
            lk_engid_q   <= lk_engid_d;
            lk_opcode_q  <= lk_opcode_d;
            lk_dat_vld_q <= lk_dat_vld_d;
            lk_dat_q     <= lk_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        eng_mem_q <= eng_mem_d;
        dat_mem_q <= dat_mem_d;
    end

`ifdef STK_PIPE_ADM_PERF_EN
    logic [2:0][31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (dsp) begin
            perf_d[sel] = perf_q[sel] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign o_perf_cnt = perf_q;
`else
    assign o_perf_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst && i_wrbk_vld_r) begin
            assert (busy_q[i_wrbk_engid_r])
            else $error("writeback for idle engine %0d", i_wrbk_engid_r);
            assert (!(acc && gnt == i_wrbk_engid_r))
            else $error("writeback collides with accept on engine %0d", gnt);
        end
    end

    assign o_lk_vld_r     = lk_vld_q;
    assign o_lk_engid_r   = lk_engid_q;
    assign o_lk_opcode_r  = lk_opcode_q;
    assign o_lk_dat_vld_r = lk_dat_vld_q;
    assign o_lk_dat_r     = lk_dat_q;
    assign o_al_alloc_r   = lk_dat_vld_q;
endmodule
